// File: rtl/stream_pkg.sv
// Shared helpers for the stream width converters: lane placement, keep masks
// and the assembly-stage state type.
package stream_pkg;

  localparam int MAX_SCALE = 64;
  localparam logic [MAX_SCALE-1:0] MASK_ONE = MAX_SCALE'(1);

  typedef enum logic {
    ASM_COLLECT,
    ASM_PENDING
  } asm_state_e;

  function automatic int lane_of(input int idx, input int scale, input int big_endian);
    return (big_endian != 0) ? (scale - 1 - idx) : idx;
  endfunction

  // Lanes holding beats 0..idx, mirrored towards the MSBs for big-endian packing.
  function automatic logic [MAX_SCALE-1:0] keep_mask(input int idx, input int scale,
                                                     input int big_endian);
    logic [MAX_SCALE-1:0] mask;
    mask = '0;
    for (int i = 0; i < MAX_SCALE; i++) begin
      if (i <= idx && i < scale) begin
        mask = mask | (MASK_ONE << lane_of(i, scale, big_endian));
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/stream_upsizer_pkt_if.sv
// Narrow input stream plus wide packed output stream of the packet upsizer.
// The slave modport is the block's view, the master modport the environment's.
interface stream_upsizer_pkt_if #(
  parameter int DW_IN = 32,
  parameter int SCALE = 4
);

  logic [DW_IN-1:0]       s_data_i;
  logic                   s_valid_i;
  logic                   s_last_i;
  logic                   s_ready_o;
  logic [DW_IN*SCALE-1:0] m_data_o;
  logic [SCALE-1:0]       m_keep_o;
  logic                   m_last_o;
  logic                   m_valid_o;
  logic                   m_ready_i;

  modport slave (
    input  s_data_i, s_valid_i, s_last_i, m_ready_i,
    output s_ready_o, m_data_o, m_keep_o, m_last_o, m_valid_o
  );

  modport master (
    output s_data_i, s_valid_i, s_last_i, m_ready_i,
    input  s_ready_o, m_data_o, m_keep_o, m_last_o, m_valid_o
  );

endinterface

// File: rtl/stream_out_reg.sv
// Valid/ready holding register for a packed word with its keep mask and last flag.
module stream_out_reg #(
  parameter int DW = 32,
  parameter int KW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] data_d,
  input  logic [KW-1:0] keep_d,
  input  logic          last_d,
  input  logic          ready,
  output logic          valid,
  output logic [DW-1:0] data_q,
  output logic [KW-1:0] keep_q,
  output logic          last_q
);

  // Contents only change on a load, so a stalled word stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid  <= 1'b0;
      data_q <= '0;
      keep_q <= '0;
      last_q <= 1'b0;
    end else if (load) begin
      valid  <= 1'b1;
      data_q <= data_d;
      keep_q <= keep_d;
      last_q <= last_d;
    end else if (ready) begin
      valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_upsizer_pkt.sv
// Packet-aware upsizer: packs SCALE narrow beats into one wide word, flushing a
// partial word with a keep mask when the packet ends early.
module stream_upsizer_pkt
  import stream_pkg::*;
#(
  parameter int DW_IN      = 32,
  parameter int SCALE      = 4,
  parameter int BIG_ENDIAN = 0,
  parameter int ZERO_FILL  = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  stream_upsizer_pkt_if.slave io
);

  localparam int WW = DW_IN * SCALE;
  localparam int IW = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam logic [WW-1:0] LANE_ONES = WW'({DW_IN{1'b1}});

  asm_state_e       state_q, state_d;
  logic [WW-1:0]    asm_data, merged, load_data, out_data;
  logic [IW-1:0]    idx;
  logic [SCALE-1:0] pend_keep, keep_now, load_keep, out_keep;
  logic             pend_last, load_last, out_last, out_valid;
  logic             rst_hold, pending, s_ready, wr, rd, out_free, complete, load;
  int               lane;

  always_comb begin
    pending  = (state_q == ASM_PENDING);
    s_ready  = !pending && !rst_hold;
    wr       = io.s_valid_i && s_ready;
    rd       = out_valid && io.m_ready_i;
    out_free = !out_valid || io.m_ready_i;
    complete = (idx == IW'(SCALE - 1)) || io.s_last_i;
    lane     = lane_of(int'(idx), SCALE, BIG_ENDIAN);
    merged   = (asm_data & ~(LANE_ONES << (lane * DW_IN)))
             | (WW'(io.s_data_i) << (lane * DW_IN));
    keep_now = SCALE'(keep_mask(int'(idx), SCALE, BIG_ENDIAN));
  end

  // A held word always drains before any new beat is accepted.
  always_comb begin
    load      = pending ? rd : (wr && complete && out_free);
    load_data = pending ? asm_data : merged;
    load_keep = pending ? pend_keep : keep_now;
    load_last = pending ? pend_last : io.s_last_i;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ASM_COLLECT: if (wr && complete && !out_free) state_d = ASM_PENDING;
      ASM_PENDING: if (rd) state_d = ASM_COLLECT;
      default:     state_d = ASM_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ASM_COLLECT;
      rst_hold <= 1'b1;
    end else begin
      state_q <= state_d;
      rst_hold <= 1'b0;
    end
  end

  // The assembly register doubles as storage for the word waiting on the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_data  <= '0;
      idx       <= '0;
      pend_keep <= '0;
      pend_last <= 1'b0;
    end else if (pending) begin
      if (rd && ZERO_FILL != 0) begin
        asm_data <= '0;
      end
    end else if (wr) begin
      if (complete) begin
        idx <= '0;
        if (!out_free) begin
          asm_data  <= merged;
          pend_keep <= keep_now;
          pend_last <= io.s_last_i;
        end else if (ZERO_FILL != 0) begin
          asm_data <= '0;
        end
      end else begin
        asm_data <= merged;
        idx      <= idx + IW'(1);
      end
    end
  end

  stream_out_reg #(
    .DW(WW),
    .KW(SCALE)
  ) u_out_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .data_d(load_data),
    .keep_d(load_keep),
    .last_d(load_last),
    .ready (io.m_ready_i),
    .valid (out_valid),
    .data_q(out_data),
    .keep_q(out_keep),
    .last_q(out_last)
  );

  assign io.s_ready_o = s_ready;
  assign io.m_data_o  = out_data;
  assign io.m_keep_o  = out_keep;
  assign io.m_last_o  = out_last;
  assign io.m_valid_o = out_valid;

endmodule

// File: tb/tb_stream_upsizer_pkt.sv
// Bench for stream_upsizer_pkt: little- and big-endian instances share one input
// stream and are scored against a beat-counting packet model.
module tb_stream_upsizer_pkt;

  localparam int DW = 8;
  localparam int SC = 4;

  typedef struct {
    logic [31:0] d_le;
    logic [31:0] d_be;
    logic [3:0]  k_le;
    logic [3:0]  k_be;
    logic        last;
  } word_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_data;
  logic        s_valid, s_last, m_ready;
  bit          random_ready;
  int          compare_count = 0;
  int          mismatch_count = 0;
  int          waited, total_wait;

  word_t       exp_q[$];
  logic [7:0]  cur_beats[$];
  logic        stall_prev;
  logic [31:0] data_prev;
  logic [3:0]  keep_prev;
  logic        last_prev;

  always #5 clk = ~clk;

  stream_upsizer_pkt_if #(.DW_IN(DW), .SCALE(SC)) if_le ();
  stream_upsizer_pkt_if #(.DW_IN(DW), .SCALE(SC)) if_be ();

  assign if_le.s_data_i  = s_data;
  assign if_le.s_valid_i = s_valid;
  assign if_le.s_last_i  = s_last;
  assign if_le.m_ready_i = m_ready;
  assign if_be.s_data_i  = s_data;
  assign if_be.s_valid_i = s_valid;
  assign if_be.s_last_i  = s_last;
  assign if_be.m_ready_i = m_ready;

  stream_upsizer_pkt #(.DW_IN(DW), .SCALE(SC), .BIG_ENDIAN(0), .ZERO_FILL(1)) dut_le (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (if_le)
  );

  stream_upsizer_pkt #(.DW_IN(DW), .SCALE(SC), .BIG_ENDIAN(1), .ZERO_FILL(1)) dut_be (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (if_be)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (random_ready) m_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Offer one beat and hold it until it is taken; inputs drop again afterwards.
  task automatic applyStimulus(input logic [7:0] data, input logic last, output int wait_cycles);
    bit accepted;
    s_valid = 1'b1;
    s_data  = data;
    s_last  = last;
    wait_cycles = 0;
    while (1) begin
      @(negedge clk);
      accepted = if_le.s_ready_o;
      tick();
      if (accepted) break;
      wait_cycles++;
      if (wait_cycles > 1000) begin
        checkOutput("accept_timeout", 32'(1), 32'(0));
        break;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Reference model: group accepted beats by count or packet end, then score
  // every output handshake in order and the stability of stalled words.
  always @(negedge clk) begin : model
    word_t w;
    if (!rst_n) begin
      cur_beats.delete();
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checkOutput("stall_data", if_le.m_data_o, data_prev);
        checkOutput("stall_keep", 32'(if_le.m_keep_o), 32'(keep_prev));
        checkOutput("stall_last", 32'(if_le.m_last_o), 32'(last_prev));
      end
      if (s_valid && if_le.s_ready_o) begin
        cur_beats.push_back(s_data);
        if (cur_beats.size() == SC || s_last) begin
          w.d_le = '0;
          w.d_be = '0;
          w.k_le = '0;
          w.k_be = '0;
          for (int i = 0; i < cur_beats.size(); i++) begin
            w.d_le[8*i +: 8]        = cur_beats[i];
            w.d_be[8*(SC-1-i) +: 8] = cur_beats[i];
            w.k_le[i]               = 1'b1;
            w.k_be[SC-1-i]          = 1'b1;
          end
          w.last = s_last;
          exp_q.push_back(w);
          cur_beats.delete();
        end
      end
      if (if_le.m_valid_o && m_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_word", 32'(1), 32'(0));
        end else begin
          w = exp_q.pop_front();
          checkOutput("le_data", if_le.m_data_o, w.d_le);
          checkOutput("le_keep", 32'(if_le.m_keep_o), 32'(w.k_le));
          checkOutput("le_last", 32'(if_le.m_last_o), 32'(w.last));
          checkOutput("be_valid", 32'(if_be.m_valid_o), 32'(1));
          checkOutput("be_data", if_be.m_data_o, w.d_be);
          checkOutput("be_keep", 32'(if_be.m_keep_o), 32'(w.k_be));
          checkOutput("be_last", 32'(if_be.m_last_o), 32'(w.last));
        end
      end
      stall_prev = if_le.m_valid_o && !m_ready;
      data_prev  = if_le.m_data_o;
      keep_prev  = if_le.m_keep_o;
      last_prev  = if_le.m_last_o;
    end
  end

  initial begin
    rst_n = 1'b1;
    s_valid = 1'b0;
    s_data = '0;
    s_last = 1'b0;
    m_ready = 1'b0;
    random_ready = 1'b0;
    total_wait = 0;

    // Reset state and the one-cycle ready hold after release.
    #1 rst_n = 1'b0;
    #2;
    checkOutput("rst_valid", 32'(if_le.m_valid_o), 32'(0));
    checkOutput("rst_data", if_le.m_data_o, 32'(0));
    checkOutput("rst_keep", 32'(if_le.m_keep_o), 32'(0));
    checkOutput("rst_last", 32'(if_le.m_last_o), 32'(0));
    checkOutput("rst_ready", 32'(if_le.s_ready_o), 32'(0));
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("hold_ready", 32'(if_le.s_ready_o), 32'(0));
    @(posedge clk);
    #1;
    checkOutput("ready_after_hold", 32'(if_le.s_ready_o), 32'(1));

    // Back-to-back full word, both lane orders.
    m_ready = 1'b1;
    applyStimulus(8'h11, 1'b0, waited); total_wait += waited;
    applyStimulus(8'h22, 1'b0, waited); total_wait += waited;
    applyStimulus(8'h33, 1'b0, waited); total_wait += waited;
    applyStimulus(8'h44, 1'b0, waited); total_wait += waited;
    checkOutput("b2b_no_stall", 32'(total_wait), 32'(0));
    checkOutput("full_valid", 32'(if_le.m_valid_o), 32'(1));
    checkOutput("full_le_data", if_le.m_data_o, 32'h44332211);
    checkOutput("full_le_keep", 32'(if_le.m_keep_o), 32'hF);
    checkOutput("full_last", 32'(if_le.m_last_o), 32'(0));
    checkOutput("full_be_data", if_be.m_data_o, 32'h11223344);
    checkOutput("full_be_keep", 32'(if_be.m_keep_o), 32'hF);

    // Early packet end: two-lane word, then a single-lane word.
    applyStimulus(8'hAA, 1'b0, waited);
    applyStimulus(8'hBB, 1'b1, waited);
    checkOutput("part2_le_data", if_le.m_data_o, 32'h0000BBAA);
    checkOutput("part2_le_keep", 32'(if_le.m_keep_o), 32'h3);
    checkOutput("part2_last", 32'(if_le.m_last_o), 32'(1));
    checkOutput("part2_be_data", if_be.m_data_o, 32'hAABB0000);
    checkOutput("part2_be_keep", 32'(if_be.m_keep_o), 32'hC);
    applyStimulus(8'hCC, 1'b1, waited);
    checkOutput("part1_le_data", if_le.m_data_o, 32'h000000CC);
    checkOutput("part1_le_keep", 32'(if_le.m_keep_o), 32'h1);
    checkOutput("part1_last", 32'(if_le.m_last_o), 32'(1));
    checkOutput("part1_be_data", if_be.m_data_o, 32'hCC000000);
    checkOutput("part1_be_keep", 32'(if_be.m_keep_o), 32'h8);

    // Backpressure: one word held on the output, the next one pending.
    tick();
    tick();
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) applyStimulus(8'(i), 1'b0, waited);
    checkOutput("bp_ready_low", 32'(if_le.s_ready_o), 32'(0));
    checkOutput("bp_valid", 32'(if_le.m_valid_o), 32'(1));
    checkOutput("bp_first_word", if_le.m_data_o, 32'h04030201);
    tick();
    checkOutput("bp_still_low", 32'(if_le.s_ready_o), 32'(0));
    m_ready = 1'b1;
    applyStimulus(8'h09, 1'b0, waited);
    checkOutput("resume_wait", 32'(waited), 32'(1));
    for (int i = 10; i <= 12; i++) applyStimulus(8'(i), 1'b0, waited);
    checkOutput("bp_third_word", if_le.m_data_o, 32'h0C0B0A09);

    // Reset mid-packet with a held output word.
    tick();
    tick();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(8'hB1 + 8'(i), 1'b0, waited);
    applyStimulus(8'hC1, 1'b0, waited);
    applyStimulus(8'hC2, 1'b0, waited);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", 32'(if_le.m_valid_o), 32'(0));
    checkOutput("midrst_data", if_le.m_data_o, 32'(0));
    checkOutput("midrst_keep", 32'(if_le.m_keep_o), 32'(0));
    checkOutput("midrst_last", 32'(if_le.m_last_o), 32'(0));
    checkOutput("midrst_ready", 32'(if_le.s_ready_o), 32'(0));
    checkOutput("midrst_be_data", if_be.m_data_o, 32'(0));
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    checkOutput("midrst_hold_ready", 32'(if_le.s_ready_o), 32'(0));
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) applyStimulus(8'hA1 + 8'(i), 1'b0, waited);
    checkOutput("clean_le_data", if_le.m_data_o, 32'hA4A3A2A1);
    checkOutput("clean_le_keep", 32'(if_le.m_keep_o), 32'hF);
    checkOutput("clean_last", 32'(if_le.m_last_o), 32'(0));
    checkOutput("clean_be_data", if_be.m_data_o, 32'hA1A2A3A4);

    // Random traffic with random stalls on both sides.
    random_ready = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 9) < 3) tick();
      applyStimulus(8'($urandom), ($urandom_range(0, 5) == 0), waited);
    end
    random_ready = 1'b0;
    m_ready = 1'b1;
    applyStimulus(8'h5A, 1'b1, waited);
    for (int i = 0; i < 200 && (exp_q.size() != 0 || if_le.m_valid_o); i++) tick();
    checkOutput("drain_queue", 32'(exp_q.size()), 32'(0));
    checkOutput("drain_valid", 32'(if_le.m_valid_o), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
